aes_key_expand: RTL and testbench

//  Iterative AES-128 key-schedule engine. Expands a 128-bit cipher key into 11 round keys, one round key per clock.

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_key_expand.sv | 130 +++++++++++++
 tb/tb_aes_key_expand.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, round-key type and GF(2^8) doubling helper.
// Used by the key schedule and the decrypt round datapath.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef logic [127:0] round_key_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, pure combinational lookup (0 cycles).
// No flow control; output follows input.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the top byte, so index x lives at bits [(255-x)*8 +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[(255 - int'(in_byte)) * 8 +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock, rk0..rk10 stored for reverse readout.
// Latency 11 edges from key_load to keys_valid; key_load is ignored while busy (no other backpressure).
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter bit RD_REG = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    round_key_t rk_q [0:NR];
    round_key_t rk_d [0:NR];
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;

    round_key_t prev_key, next_key, rd_key_c;
    logic [31:0] rot_word, sub_word, temp_word, carry, word;
    logic        load_go;

    assign load_go = key_load && !busy_q;

    // The previous round key is whatever was written on the last edge.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (round_q == 4'(i + 1)) prev_key = rk_q[i];
        end
    end

    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*b +: 8]),
            .out_byte (sub_word[8*b +: 8])
        );
    end

    assign temp_word = sub_word ^ {rcon_q, 24'h0};

    always_comb begin
        next_key = '0;
        carry    = temp_word;
        word     = '0;
        for (int i = 0; i < AES_NK; i++) begin
            word                       = prev_key[127 - 32*i -: 32] ^ carry;
            next_key[127 - 32*i -: 32] = word;
            carry                      = word;
        end
    end

    always_comb begin
        rk_d    = rk_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        if (load_go) begin
            rk_d[0] = key_in;
            rcon_d  = RCON_INIT;
            round_d = 4'd1;
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end else if (busy_q) begin
            for (int i = 0; i <= NR; i++) begin
                if (round_q == 4'(i)) rk_d[i] = next_key;
            end
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
            if (round_q == LAST_ROUND) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            round_q <= round_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Storage is deliberately not cleared by reset, only frozen while it is held.
    always_ff @(posedge clk) begin
        if (!rst) rk_q <= rk_d;
    end

    assign busy       = busy_q;
    assign keys_valid = valid_q;

    always_comb begin
        rd_key_c = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rd_idx == 4'(i)) rd_key_c = rk_q[i];
        end
    end

    if (RD_REG) begin : g_rd_reg
        round_key_t rd_key_q, rd_key_d;
        assign rd_key_d = rd_key_c;
        always_ff @(posedge clk) begin
            if (rst) rd_key_q <= '0;
            else     rd_key_q <= rd_key_d;
        end
        assign rd_key = rd_key_q;
    end else begin : g_rd_comb
        assign rd_key = rd_key_c;
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: known-answer table, corner sequences and random keys
// against a key-schedule model built from GF(2^8) arithmetic.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst, key_load;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic         busy0, kv0, busy1, kv1;
    logic [127:0] rk0_o, rk1_o;

    always #5 clk = ~clk;

    aes_key_expand #(.NR(10), .RD_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .busy(busy0), .keys_valid(kv0), .rd_idx(rd_idx), .rd_key(rk0_o)
    );

    aes_key_expand #(.NR(10), .RD_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .busy(busy1), .keys_valid(kv1), .rd_idx(rd_idx), .rd_key(rk1_o)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] sbox_m [256];

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] xb, inv;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_rk(input logic [127:0] key, input int idx);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        if (idx > 10) return 128'h0;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // Edges counted from the load edge (which is edge 1); bounded.
    task automatic wait_done(input int start, output int edges);
        edges = start;
        while (!kv0 && edges < 40) begin
            tick();
            edges++;
        end
        check_int("expand_done", int'(kv0), 1);
    endtask

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    initial begin
        int           e;
        logic [127:0] k;
        logic [127:0] exp_rk [11];

        rst = 1'b1; key_load = 1'b0; key_in = '0; rd_idx = 4'd0;
        build_sbox();

        vecs[0] = '{"a1_rk1",   KEY_A1,   4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{"a1_rk10",  KEY_A1,   4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[2] = '{"a1_rk0",   KEY_A1,   4'd0,  KEY_A1};
        vecs[3] = '{"a1_idx12", KEY_A1,   4'd12, 128'h0};
        vecs[4] = '{"zero_rk10",KEY_ZERO, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[5] = '{"zero_rk1", KEY_ZERO, 4'd1,  128'h62636363626363636263636362636363};
        vecs[6] = '{"zero_rk0", KEY_ZERO, 4'd0,  128'h0};

        // Reset state
        tick(); tick();
        check_int("rst_busy0", int'(busy0), 0);
        check_int("rst_valid0", int'(kv0), 0);
        check_int("rst_busy1", int'(busy1), 0);
        check_int("rst_valid1", int'(kv1), 0);
        check128("rst_rdkey_reg", rk1_o, 128'h0);
        rst = 1'b0;
        tick();

        // Cycle-exact busy / keys_valid profile
        load_key(KEY_A1);
        check_int("lat_busy_t1", int'(busy0), 1);
        check_int("lat_valid_t1", int'(kv0), 0);
        repeat (9) tick();
        check_int("lat_busy_t10", int'(busy0), 1);
        check_int("lat_valid_t10", int'(kv0), 0);
        tick();
        check_int("lat_busy_t11", int'(busy0), 0);
        check_int("lat_valid_t11", int'(kv0), 1);

        // Known-answer table, both read modes
        foreach (vecs[v]) begin
            load_key(vecs[v].key);
            wait_done(1, e);
            check_int({vecs[v].name, "_latency"}, e, 11);
            rd_idx = vecs[v].idx;
            #1;
            check128(vecs[v].name, rk0_o, vecs[v].exp);
            tick();
            check128({vecs[v].name, "_reg"}, rk1_o, vecs[v].exp);
        end

        // key_load during expansion is ignored
        load_key(KEY_A1);
        repeat (3) tick();
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        wait_done(5, e);
        check_int("ignore_latency", e, 11);
        rd_idx = 4'd1; #1;
        check128("ignore_rk1", rk0_o, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_idx = 4'd10; #1;
        check128("ignore_rk10", rk0_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset mid-expansion aborts; a fresh load completes
        load_key(KEY_ZERO);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_int("abort_busy", int'(busy0), 0);
        check_int("abort_valid", int'(kv0), 0);
        repeat (12) tick();
        check_int("abort_valid_hold", int'(kv0), 0);
        check_int("abort_busy_hold", int'(busy0), 0);
        k = {$urandom, $urandom, $urandom, $urandom};
        load_key(k);
        wait_done(1, e);
        check_int("abort_reload_latency", e, 11);
        rd_idx = 4'd10; #1;
        check128("abort_reload_rk10", rk0_o, model_rk(k, 10));
        rd_idx = 4'd5; #1;
        check128("abort_reload_rk5", rk0_o, model_rk(k, 5));

        // Random keys, restart from keys_valid, reverse readout in both read modes
        for (int r = 0; r < 4; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 11; i++) exp_rk[i] = model_rk(k, i);
            load_key(k);
            check_int("restart_valid_drop", int'(kv0), 0);
            wait_done(1, e);
            check_int("rand_latency", e, 11);
            rd_idx = 4'd10;
            tick();
            for (int i = 10; i >= 0; i--) begin
                rd_idx = 4'(i);
                #1;
                check128("rand_rev_comb", rk0_o, exp_rk[i]);
                check128("rand_rev_reg_old", rk1_o, exp_rk[(i == 10) ? 10 : i + 1]);
                tick();
                check128("rand_rev_reg", rk1_o, exp_rk[i]);
            end
            rd_idx = 4'd12;
            #1;
            check128("rand_idx12_comb", rk0_o, 128'h0);
            tick();
            check128("rand_idx12_reg", rk1_o, 128'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
